// File: rtl/dhcp_vlg_rx_parse.sv
// dhcp_vlg_rx_parse
// Receive-side DHCP message parser. Consumes the UDP payload bytes of frames
// already matched to client port 68, checks the fixed BOOTP header length and
// the magic cookie, walks the option list and presents one result per frame on
// an out_val / out_done handshake.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   in_dat[7:0]       payload byte
//   in_val            in_dat valid (no state change while low)
//   in_sof, in_eof    first / last payload byte, qualified by in_val
//   out_val           result valid, held until out_done
//   out_err           frame malformed (meaningful while out_val)
//   out_done          consumer acknowledge
//   op, xid, yiaddr   BOOTP op, transaction id, offered address
//   msg_type          option 53
//   subnet_mask       option 1
//   router            option 3 (first address)
//   lease_time        option 51
//   server_id         option 54
//   opt_pres[4:0]     presence flags for options 53, 1, 3, 51, 54
module dhcp_vlg_rx_parse #(
    parameter int MAX_OPT_LEN = 312
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_dat,
    input  logic        in_val,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic        out_val,
    output logic        out_err,
    input  logic        out_done,
    output logic [7:0]  op,
    output logic [31:0] xid,
    output logic [31:0] yiaddr,
    output logic [7:0]  msg_type,
    output logic [31:0] subnet_mask,
    output logic [31:0] router,
    output logic [31:0] lease_time,
    output logic [31:0] server_id,
    output logic [4:0]  opt_pres
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FIXED    = 3'd1;
    localparam logic [2:0] S_COOKIE   = 3'd2;
    localparam logic [2:0] S_OPT_CODE = 3'd3;
    localparam logic [2:0] S_OPT_LEN  = 3'd4;
    localparam logic [2:0] S_OPT_DATA = 3'd5;
    localparam logic [2:0] S_SKIP_EOF = 3'd6;
    localparam logic [2:0] S_HOLD     = 3'd7;

    localparam logic [8:0] OPT_LIMIT = 9'(MAX_OPT_LEN);

    logic [2:0]  state, state_n;
    logic [8:0]  byte_cnt, byte_cnt_n;
    logic [8:0]  opt_cnt, opt_cnt_n;
    logic [7:0]  opt_code, opt_code_n;
    logic [7:0]  opt_len, opt_len_n;
    logic [7:0]  opt_rem, opt_rem_n;
    logic [31:0] opt_shift, opt_shift_n;
    logic        out_val_n, out_err_n;
    logic [7:0]  op_n, msg_type_n;
    logic [31:0] xid_n, yiaddr_n, subnet_mask_n, router_n, lease_time_n, server_id_n;
    logic [4:0]  opt_pres_n;
    logic [7:0]  cookie_byte;
    logic [7:0]  opt_kept;
    logic [8:0]  opt_cnt_inc;
    logic        len_is_4;

    always_comb begin
        // NOTE: every next-state signal is defaulted to its current value first,
        // so no path through the branches below can infer a latch.
        state_n       = state;
        byte_cnt_n    = byte_cnt;
        opt_cnt_n     = opt_cnt;
        opt_code_n    = opt_code;
        opt_len_n     = opt_len;
        opt_rem_n     = opt_rem;
        opt_shift_n   = opt_shift;
        out_val_n     = out_val;
        out_err_n     = out_err;
        op_n          = op;
        xid_n         = xid;
        yiaddr_n      = yiaddr;
        msg_type_n    = msg_type;
        subnet_mask_n = subnet_mask;
        router_n      = router;
        lease_time_n  = lease_time;
        server_id_n   = server_id;
        opt_pres_n    = opt_pres;

        // Cookie bytes 236..239 line up with byte_cnt[1:0] = 0..3.
        case (byte_cnt[1:0])
            2'd0:    cookie_byte = 8'h63;
            2'd1:    cookie_byte = 8'h82;
            2'd2:    cookie_byte = 8'h53;
            default: cookie_byte = 8'h63;
        endcase
        opt_cnt_inc = (opt_cnt == 9'h1FF) ? opt_cnt : opt_cnt + 9'd1;
        opt_kept    = opt_len - opt_rem;   // data bytes of this option already seen
        len_is_4    = (opt_len == 8'd4);

        if (state == S_HOLD) begin
            // Bytes arriving here are dropped, including a new in_sof.
            if (out_done) begin
                out_val_n = 1'b0;
                state_n   = S_IDLE;
            end
        end else if (in_val) begin
            if (in_sof) begin
                // Start of frame, or a mid-frame restart that silently aborts the old one.
                state_n       = S_FIXED;
                byte_cnt_n    = 9'd1;
                opt_cnt_n     = '0;
                out_err_n     = 1'b0;
                op_n          = in_dat;
                xid_n         = '0;
                yiaddr_n      = '0;
                msg_type_n    = '0;
                subnet_mask_n = '0;
                router_n      = '0;
                lease_time_n  = '0;
                server_id_n   = '0;
                opt_pres_n    = '0;
                if (in_eof) begin
                    out_err_n = 1'b1;
                    out_val_n = 1'b1;
                    state_n   = S_HOLD;
                end
            end else if (state != S_IDLE) begin
                byte_cnt_n = (byte_cnt == 9'h1FF) ? byte_cnt : byte_cnt + 9'd1;
                case (state)
                    S_FIXED: begin
                        if (byte_cnt >= 9'd4 && byte_cnt <= 9'd7)
                            xid_n = {xid[23:0], in_dat};
                        if (byte_cnt >= 9'd16 && byte_cnt <= 9'd19)
                            yiaddr_n = {yiaddr[23:0], in_dat};
                        if (byte_cnt == 9'd235)
                            state_n = S_COOKIE;
                    end
                    S_COOKIE: begin
                        if (in_dat != cookie_byte) begin
                            out_err_n = 1'b1;
                            state_n   = S_SKIP_EOF;
                        end else if (byte_cnt == 9'd239) begin
                            state_n = S_OPT_CODE;
                        end
                    end
                    S_OPT_CODE, S_OPT_LEN, S_OPT_DATA: begin
                        opt_cnt_n = opt_cnt_inc;
                        if (opt_cnt_inc > OPT_LIMIT) begin
                            out_err_n = 1'b1;
                            state_n   = S_SKIP_EOF;
                        end else if (state == S_OPT_CODE) begin
                            if (in_dat == 8'hFF) begin
                                state_n = S_SKIP_EOF;
                            end else if (in_dat != 8'h00) begin
                                opt_code_n = in_dat;
                                state_n    = S_OPT_LEN;
                            end
                        end else if (state == S_OPT_LEN) begin
                            opt_len_n   = in_dat;
                            opt_rem_n   = in_dat;
                            opt_shift_n = '0;
                            state_n     = (in_dat == 8'h00) ? S_OPT_CODE : S_OPT_DATA;
                        end else begin
                            opt_rem_n = opt_rem - 8'd1;
                            // Only the first four data bytes are kept (router takes the first address).
                            if (opt_kept < 8'd4)
                                opt_shift_n = {opt_shift[23:0], in_dat};
                            if (opt_rem == 8'd1) begin
                                state_n = S_OPT_CODE;
                                case (opt_code)
                                    8'd53: begin
                                        if (opt_len == 8'd1) begin
                                            msg_type_n    = opt_shift_n[7:0];
                                            opt_pres_n[0] = 1'b1;
                                        end else out_err_n = 1'b1;
                                    end
                                    8'd1: begin
                                        if (len_is_4) begin
                                            subnet_mask_n = opt_shift_n;
                                            opt_pres_n[1] = 1'b1;
                                        end else out_err_n = 1'b1;
                                    end
                                    8'd3: begin
                                        if (opt_len >= 8'd4 && opt_len[1:0] == 2'b00) begin
                                            router_n      = opt_shift_n;
                                            opt_pres_n[2] = 1'b1;
                                        end else out_err_n = 1'b1;
                                    end
                                    8'd51: begin
                                        if (len_is_4) begin
                                            lease_time_n  = opt_shift_n;
                                            opt_pres_n[3] = 1'b1;
                                        end else out_err_n = 1'b1;
                                    end
                                    8'd54: begin
                                        if (len_is_4) begin
                                            server_id_n   = opt_shift_n;
                                            opt_pres_n[4] = 1'b1;
                                        end else out_err_n = 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                    default: ;   // S_SKIP_EOF discards bytes
                endcase

                if (in_eof) begin
                    out_val_n = 1'b1;
                    state_n   = S_HOLD;
                    // Clean only when already skipping after an end option, or this byte is the end.
                    if (!(state == S_SKIP_EOF || (state == S_OPT_CODE && in_dat == 8'hFF)) ||
                        !opt_pres_n[0])
                        out_err_n = 1'b1;
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values computed above for this same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            byte_cnt    <= '0;
            opt_cnt     <= '0;
            opt_code    <= '0;
            opt_len     <= '0;
            opt_rem     <= '0;
            opt_shift   <= '0;
            out_val     <= 1'b0;
            out_err     <= 1'b0;
            op          <= '0;
            xid         <= '0;
            yiaddr      <= '0;
            msg_type    <= '0;
            subnet_mask <= '0;
            router      <= '0;
            lease_time  <= '0;
            server_id   <= '0;
            opt_pres    <= '0;
        end else begin
            state       <= state_n;
            byte_cnt    <= byte_cnt_n;
            opt_cnt     <= opt_cnt_n;
            opt_code    <= opt_code_n;
            opt_len     <= opt_len_n;
            opt_rem     <= opt_rem_n;
            opt_shift   <= opt_shift_n;
            out_val     <= out_val_n;
            out_err     <= out_err_n;
            op          <= op_n;
            xid         <= xid_n;
            yiaddr      <= yiaddr_n;
            msg_type    <= msg_type_n;
            subnet_mask <= subnet_mask_n;
            router      <= router_n;
            lease_time  <= lease_time_n;
            server_id   <= server_id_n;
            opt_pres    <= opt_pres_n;
        end
    end

endmodule

// File: tb/tb_dhcp_vlg_rx_parse.sv
// Testbench for dhcp_vlg_rx_parse. Frames are built as byte queues; a
// whole-frame reference parser produces the expected result, which a compare
// process checks against the DUT on every cycle out_val is high.
module tb_dhcp_vlg_rx_parse;

    localparam int MAX_OPT = 312;

    typedef struct packed {
        logic        err;
        logic [7:0]  op;
        logic [31:0] xid;
        logic [31:0] yiaddr;
        logic [7:0]  msg_type;
        logic [31:0] subnet;
        logic [31:0] router;
        logic [31:0] lease;
        logic [31:0] server;
        logic [4:0]  pres;
    } result_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_dat = '0;
    logic        in_val = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_eof = 1'b0;
    logic        out_done = 1'b0;
    logic        out_val, out_err;
    logic [7:0]  op, msg_type;
    logic [31:0] xid, yiaddr, subnet_mask, router, lease_time, server_id;
    logic [4:0]  opt_pres;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] frm[$];
    result_t    exp_q[$];
    result_t    cur;
    result_t    r;

    dhcp_vlg_rx_parse #(.MAX_OPT_LEN(MAX_OPT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_dat(in_dat), .in_val(in_val), .in_sof(in_sof), .in_eof(in_eof),
        .out_val(out_val), .out_err(out_err), .out_done(out_done),
        .op(op), .xid(xid), .yiaddr(yiaddr), .msg_type(msg_type),
        .subnet_mask(subnet_mask), .router(router), .lease_time(lease_time),
        .server_id(server_id), .opt_pres(opt_pres)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference parser: walks the complete frame as an array.
    function automatic result_t model(input logic [7:0] f[$]);
        result_t    res;
        int         n, p, lenv;
        logic [7:0] code;
        logic [31:0] v;
        logic [7:0] ck [4];
        bit         ended;
        ck = '{8'h63, 8'h82, 8'h53, 8'h63};
        res = '0;
        n = f.size();
        if (n == 0) return res;
        res.op = f[0];
        for (int i = 4; i < 8; i++)   if (i < n) res.xid    = {res.xid[23:0], f[i]};
        for (int i = 16; i < 20; i++) if (i < n) res.yiaddr = {res.yiaddr[23:0], f[i]};
        if (n < 240) begin res.err = 1'b1; return res; end
        for (int k = 0; k < 4; k++)
            if (f[236+k] != ck[k]) begin res.err = 1'b1; return res; end
        p = 240;
        ended = 0;
        while (!ended) begin
            if (p >= n || p - 239 > MAX_OPT) begin res.err = 1'b1; break; end
            code = f[p];
            p++;
            if (code == 8'd255) ended = 1;
            else if (code != 8'd0) begin
                if (p >= n || p - 239 > MAX_OPT) begin res.err = 1'b1; break; end
                lenv = int'(f[p]);
                p++;
                if (lenv != 0) begin
                    if (p + lenv > n || p + lenv - 1 - 239 > MAX_OPT) begin res.err = 1'b1; break; end
                    v = '0;
                    for (int j = 0; j < ((lenv < 4) ? lenv : 4); j++) v = {v[23:0], f[p+j]};
                    case (code)
                        8'd53: if (lenv == 1) begin res.msg_type = v[7:0]; res.pres[0] = 1'b1; end else res.err = 1'b1;
                        8'd1:  if (lenv == 4) begin res.subnet = v; res.pres[1] = 1'b1; end else res.err = 1'b1;
                        8'd3:  if (lenv >= 4 && lenv % 4 == 0) begin res.router = v; res.pres[2] = 1'b1; end else res.err = 1'b1;
                        8'd51: if (lenv == 4) begin res.lease = v; res.pres[3] = 1'b1; end else res.err = 1'b1;
                        8'd54: if (lenv == 4) begin res.server = v; res.pres[4] = 1'b1; end else res.err = 1'b1;
                        default: ;
                    endcase
                    p += lenv;
                end
            end
        end
        if (!res.pres[0]) res.err = 1'b1;
        return res;
    endfunction

    // Compare process: every cycle a result is presented.
    always @(negedge clk) begin
        if (rst_n && out_val) begin
            if (exp_q.size() == 0) begin
                check("spurious_val", 32'(out_val), 32'd0);
            end else begin
                cur = exp_q[0];
                check("err",      32'(out_err),  32'(cur.err));
                check("op",       32'(op),       32'(cur.op));
                check("xid",      xid,           cur.xid);
                check("yiaddr",   yiaddr,        cur.yiaddr);
                check("msg_type", 32'(msg_type), 32'(cur.msg_type));
                check("subnet",   subnet_mask,   cur.subnet);
                check("router",   router,        cur.router);
                check("lease",    lease_time,    cur.lease);
                check("server",   server_id,     cur.server);
                check("opt_pres", 32'(opt_pres), 32'(cur.pres));
                if (out_done) void'(exp_q.pop_front());
            end
        end
    end

    task automatic fr_add(input logic [7:0] b);
        frm.push_back(b);
    endtask

    task automatic fr_opt4(input logic [7:0] code, input logic [31:0] v);
        fr_add(code); fr_add(8'd4);
        fr_add(v[31:24]); fr_add(v[23:16]); fr_add(v[15:8]); fr_add(v[7:0]);
    endtask

    // Fixed 236-byte BOOTP header plus the magic cookie.
    task automatic fr_fixed(input logic [7:0] op_b, input logic [31:0] x, input logic [31:0] yi);
        frm.delete();
        for (int i = 0; i < 236; i++) begin
            if (i == 0)                 fr_add(op_b);
            else if (i == 1)            fr_add(8'd1);
            else if (i == 2)            fr_add(8'd6);
            else if (i >= 4 && i <= 7)  fr_add(8'(x >> (8 * (7 - i))));
            else if (i >= 16 && i <= 19) fr_add(8'(yi >> (8 * (19 - i))));
            else                        fr_add(8'(i * 7));
        end
        fr_add(8'h63); fr_add(8'h82); fr_add(8'h53); fr_add(8'h63);
    endtask

    task automatic build_offer(input logic [31:0] x);
        fr_fixed(8'd2, x, 32'hC0A80164);
        fr_add(8'd53); fr_add(8'd1); fr_add(8'd2);
        fr_opt4(8'd1,  32'hFFFFFF00);
        fr_opt4(8'd3,  32'hC0A80101);
        fr_opt4(8'd51, 32'd86400);
        fr_opt4(8'd54, 32'hC0A80101);
        fr_add(8'd255);
    endtask

    task automatic build_ack();
        fr_fixed(8'd2, 32'h12345678, 32'h0A010203);
        fr_add(8'd53); fr_add(8'd1); fr_add(8'd5);
        fr_opt4(8'd54, 32'h0A010201);
        fr_opt4(8'd51, 32'h00000E10);
        fr_add(8'd255);
    endtask

    // Drive frm[first..last]; optional idle gaps carry garbage sof/eof with in_val low.
    task automatic send(input int first, input int last_i, input bit gaps, input bit expect_val);
        for (int i = first; i <= last_i; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_val = 1'b0; in_sof = 1'b1; in_eof = 1'b1; in_dat = 8'($urandom);
                @(posedge clk); #1;
            end
            in_val = 1'b1;
            in_dat = frm[i];
            in_sof = (i == 0);
            in_eof = (i == frm.size() - 1);
            @(posedge clk); #1;
        end
        in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        if (last_i == frm.size() - 1) check("val_after_eof", 32'(out_val), 32'(expect_val));
    endtask

    task automatic finish_frame(input int wait_cycles);
        repeat (wait_cycles) begin @(posedge clk); #1; end
        out_done = 1'b1;
        @(posedge clk); #1;
        out_done = 1'b0;
        check("val_drop", 32'(out_val), 32'd0);
    endtask

    task automatic run_frame(input bit gaps, input int wait_cycles);
        exp_q.push_back(model(frm));
        send(0, frm.size() - 1, gaps, 1'b1);
        finish_frame(wait_cycles);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_val",  32'(out_val),  32'd0);
        check("rst_err",  32'(out_err),  32'd0);
        check("rst_xid",  xid,           32'd0);
        check("rst_pres", 32'(opt_pres), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Valid OFFER, acknowledged at once: out_val lasts exactly one cycle.
        build_offer(32'hDEADBEEF);
        r = model(frm);
        check("model_offer_lease", r.lease, 32'h00015180);
        check("model_offer_pres",  32'(r.pres), 32'h1F);
        check("model_offer_err",   32'(r.err),  32'd0);
        exp_q.push_back(r);
        send(0, frm.size() - 1, 1'b0, 1'b1);
        check("offer_lease_lit", lease_time, 32'h00015180);
        check("offer_xid_lit",   xid,        32'hDEADBEEF);
        finish_frame(0);

        // Same OFFER with in_val gaps.
        run_frame(1'b1, 3);

        // Bad cookie byte 239.
        build_offer(32'h01020304);
        frm[239] = 8'h64;
        r = model(frm);
        check("model_cookie_err",  32'(r.err),  32'd1);
        check("model_cookie_pres", 32'(r.pres), 32'd0);
        exp_q.push_back(r);
        send(0, frm.size() - 1, 1'b0, 1'b1);
        check("cookie_err_lit", 32'(out_err), 32'd1);
        finish_frame(1);

        // Two routers, pads and unknown option 12, trailing bytes after end.
        fr_fixed(8'd2, 32'hCAFEF00D, 32'h0A000064);
        fr_add(8'd53); fr_add(8'd1); fr_add(8'd2);
        fr_add(8'd0); fr_add(8'd0);
        fr_add(8'd12); fr_add(8'd5);
        for (int i = 0; i < 5; i++) fr_add(8'h41 + 8'(i));
        fr_add(8'd0);
        fr_add(8'd3); fr_add(8'd8);
        fr_add(8'd10); fr_add(8'd0); fr_add(8'd0); fr_add(8'd1);
        fr_add(8'd10); fr_add(8'd0); fr_add(8'd0); fr_add(8'd2);
        fr_add(8'd255); fr_add(8'd0); fr_add(8'd7);
        r = model(frm);
        check("model_router",     r.router,      32'h0A000001);
        check("model_router_err", 32'(r.err),    32'd0);
        exp_q.push_back(r);
        send(0, frm.size() - 1, 1'b1, 1'b1);
        check("router_lit", router, 32'h0A000001);
        finish_frame(2);

        // Truncated in the middle of option 51.
        fr_fixed(8'd2, 32'h0BADF00D, 32'h0);
        fr_add(8'd53); fr_add(8'd1); fr_add(8'd5);
        fr_add(8'd51); fr_add(8'd4); fr_add(8'd0); fr_add(8'd1);
        r = model(frm);
        check("model_trunc_err",   32'(r.err),     32'd1);
        check("model_trunc_pres3", 32'(r.pres[3]), 32'd0);
        run_frame(1'b0, 0);

        // Illegal option lengths: 53 length 2 alone, then 1 length 3.
        fr_fixed(8'd2, 32'h11111111, 32'h0);
        fr_add(8'd53); fr_add(8'd2); fr_add(8'd5); fr_add(8'd5);
        fr_add(8'd255);
        run_frame(1'b0, 0);
        fr_fixed(8'd2, 32'h22222222, 32'h0);
        fr_add(8'd53); fr_add(8'd1); fr_add(8'd3);
        fr_add(8'd1); fr_add(8'd3); fr_add(8'hFF); fr_add(8'hFF); fr_add(8'h00);
        fr_add(8'd255);
        run_frame(1'b0, 1);

        // Option field exactly at the limit, then one byte over.
        for (int extra = 0; extra < 2; extra++) begin
            fr_fixed(8'd2, 32'h33330000 + 32'(extra), 32'h0);
            fr_add(8'd53); fr_add(8'd1); fr_add(8'd1);
            for (int i = 0; i < 308 + extra; i++) fr_add(8'd0);
            fr_add(8'd255);
            r = model(frm);
            check("model_optlimit_err", 32'(r.err), 32'(extra));
            run_frame(1'b0, 0);
        end

        // sof and eof on the same byte.
        frm.delete();
        fr_add(8'd1);
        run_frame(1'b0, 0);

        // Second frame starting while out_done is held low for 20 cycles is lost.
        build_offer(32'hDEADBEEF);
        exp_q.push_back(model(frm));
        send(0, frm.size() - 1, 1'b0, 1'b1);
        build_ack();
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                send(0, frm.size() - 1, 1'b0, 1'b0);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                out_done = 1'b1;
                @(posedge clk); #1;
                out_done = 1'b0;
                check("hold_drop", 32'(out_val), 32'd0);
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_drop", 32'(out_val), 32'd0);

        // Mid-frame in_sof aborts the partial frame and parses the new one.
        build_offer(32'hAAAAAAAA);
        send(0, 49, 1'b0, 1'b0);
        build_ack();
        run_frame(1'b1, 1);

        // Reset at byte 100, rest of that frame ignored, then a clean ACK.
        build_ack();
        send(0, 99, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midrst_xid", xid, 32'd0);
        check("midrst_val", 32'(out_val), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(100, frm.size() - 1, 1'b0, 1'b0);
        exp_q.push_back(model(frm));
        send(0, frm.size() - 1, 1'b0, 1'b1);
        check("ack_msg_type_lit", 32'(msg_type), 32'd5);
        check("ack_err_lit",      32'(out_err),  32'd0);
        finish_frame(2);

        repeat (3) @(posedge clk);
        #1;
        check("all_results_consumed", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
